// File: rtl/regfile_write_arbiter_if.sv
// ============================================================================
// Module : regfile_write_arbiter_if
// Brief  : Requester / register-file bundle for the shared write-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 2
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*SEL_W-1:0]  req_sel;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      wr_hold;
    logic [SEL_W-1:0]          rd_sel;
    logic                      rd_stall;
    logic                      reg_write;
    logic [SEL_W-1:0]          reg_sel;
    logic [DATA_W-1:0]         data_in;
    logic                      illegal_sel;
    logic [7:0]                wr_count;

    modport slave (
        input  req_valid, req_sel, req_data, wr_hold, rd_sel,
        output req_ready, rd_stall, reg_write, reg_sel, data_in, illegal_sel, wr_count
    );

    modport master (
        output req_valid, req_sel, req_data, wr_hold, rd_sel,
        input  req_ready, rd_stall, reg_write, reg_sel, data_in, illegal_sel, wr_count
    );
endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module : regfile_write_arbiter
// Brief  : Round-robin arbiter for the register-file write port, muxing reg_sel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 2,
    parameter int NUM_REGS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0] c_one      = PTR_W'(1);
    localparam logic [SEL_W:0]   c_regs_lim = (SEL_W + 1)'(NUM_REGS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    w_rr_next;
    logic [SEL_W-1:0]    r_wr_sel;
    logic [DATA_W-1:0]   r_data;
    logic                r_illegal;
    logic [7:0]          r_count;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_any;
    logic [PTR_W-1:0]    w_scan;
    logic [PTR_W-1:0]    w_gidx;
    logic [SEL_W-1:0]    w_gsel;
    logic [DATA_W-1:0]   w_gdata;
    logic                w_legal;
    logic                w_drop;

    // Scan from the round-robin pointer; the first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_scan  = '0;
        w_gidx  = '0;
        if (!rst && !bus.wr_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_any && bus.req_valid[w_scan]) begin
                    w_any           = 1'b1;
                    w_grant[w_scan] = 1'b1;
                    w_gidx          = w_scan;
                end
            end
        end
    end

    always_comb begin
        w_gsel  = '0;
        w_gdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gsel  = bus.req_sel[i*SEL_W +: SEL_W];
                w_gdata = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_legal   = ({1'b0, w_gsel} < c_regs_lim);
    assign w_drop    = w_any && !w_legal;
    assign w_rr_next = (w_gidx == c_last_idx) ? '0 : (w_gidx + c_one);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A dropped (illegal) grant still completes the handshake but never issues.
    always_comb begin
        w_state_next = IDLE;
        if (w_any && w_legal) begin
            w_state_next = ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_sel  <= '0;
            r_data    <= '0;
            r_rr_ptr  <= '0;
            r_illegal <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            if (w_any) begin
                r_wr_sel <= w_gsel;
                r_data   <= w_gdata;
                r_rr_ptr <= w_rr_next;
            end
            if (w_drop) begin
                r_illegal <= 1'b1;
            end
            if (r_state == ISSUE && r_count != 8'hFF) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign bus.req_ready   = w_grant;
    assign bus.reg_write   = (r_state == ISSUE);
    assign bus.rd_stall    = (r_state == ISSUE);
    assign bus.reg_sel     = (r_state == ISSUE) ? r_wr_sel : bus.rd_sel;
    assign bus.data_in     = r_data;
    assign bus.illegal_sel = r_illegal;
    assign bus.wr_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module : tb_regfile_write_arbiter
// Brief  : Directed + randomized bench against a behavioural arbiter model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_write_arbiter_if #(.NUM_REQ(N), .DATA_W(8), .SEL_W(2)) bus ();

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(8), .SEL_W(2), .NUM_REGS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int       m_rr;
    bit       m_write;
    bit [1:0] m_sel;
    bit [7:0] m_data;
    bit       m_ill;
    int       m_cnt;
    int       last_grant;

    bit       pend [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        if (rst || bus.wr_hold) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_write = 0; m_sel = 0; m_data = 0; m_ill = 0; m_cnt = 0;
        last_grant = -1;
    endtask

    task automatic model_update();
        int g;
        last_grant = -1;
        if (rst) return;
        g = pick();
        if (m_write && m_cnt < 255) m_cnt++;
        if (g >= 0) begin
            m_sel      = bus.req_sel[g*2 +: 2];
            m_data     = bus.req_data[g*8 +: 8];
            m_write    = (m_sel < 3);
            if (m_sel >= 3) m_ill = 1;
            m_rr       = (g + 1) % N;
            last_grant = g;
        end else begin
            m_write = 0;
        end
    endtask

    task automatic check_all();
        int g;
        logic [31:0] exp_ready;
        g = pick();
        exp_ready = (g < 0) ? 32'd0 : (32'd1 << g);
        chk("req_ready",   32'(bus.req_ready),   exp_ready);
        chk("reg_write",   32'(bus.reg_write),   32'(m_write));
        chk("rd_stall",    32'(bus.rd_stall),    32'(m_write));
        chk("reg_sel",     32'(bus.reg_sel),     m_write ? 32'(m_sel) : 32'(bus.rd_sel));
        chk("data_in",     32'(bus.data_in),     32'(m_data));
        chk("illegal_sel", 32'(bus.illegal_sel), 32'(m_ill));
        chk("wr_count",    32'(bus.wr_count),    32'(m_cnt));
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic edge_();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit [1:0] s, input bit [7:0] d);
        bus.req_valid[i]      = v;
        bus.req_sel[i*2 +: 2] = s;
        bus.req_data[i*8 +: 8] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
        chk("rst_data_in",   32'(bus.data_in),   32'd0);
        chk("rst_wr_count",  32'(bus.wr_count),  32'd0);
        chk("rst_ready",     32'(bus.req_ready), 32'd0);
        edge_();
        bus.req_valid = '0;
        rst = 1'b0;
        settle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_sel   = '0;
        bus.req_data  = '0;
        bus.wr_hold   = 1'b0;
        bus.rd_sel    = 2'd2;
        for (int i = 0; i < N; i++) pend[i] = 0;
        model_reset();
        settle();
        chk("init_wr_count", 32'(bus.wr_count), 32'd0);
        edge_();
        rst = 1'b0;
        settle();

        // Single request, latency and read-select mux
        set_req(0, 1, 2'd1, 8'hA5);
        settle();
        chk("single_ready", 32'(bus.req_ready), 32'd1);
        edge_();
        bus.req_valid = '0;
        settle();
        chk("single_wr",    32'(bus.reg_write), 32'd1);
        chk("single_sel",   32'(bus.reg_sel),   32'd1);
        chk("single_data",  32'(bus.data_in),   32'hA5);
        chk("single_stall", 32'(bus.rd_stall),  32'd1);
        edge_();
        settle();
        chk("single_idle",  32'(bus.reg_write), 32'd0);
        chk("single_rdsel", 32'(bus.reg_sel),   32'd2);

        // Reset while a write is issuing
        set_req(1, 1, 2'd2, 8'h3C);
        settle();
        edge_();
        bus.req_valid = '0;
        settle();
        chk("pre_rst_wr", 32'(bus.reg_write), 32'd1);
        do_reset();
        edge_();
        settle();
        chk("post_rst_wr", 32'(bus.reg_write), 32'd0);

        // Full contention from reset
        set_req(0, 1, 2'd0, 8'h11);
        set_req(1, 1, 2'd1, 8'h22);
        set_req(2, 1, 2'd2, 8'h33);
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("rr_order", 32'(bus.req_ready), 32'd1 << (c % 3));
            edge_();
        end
        bus.req_valid = '0;
        settle();
        edge_();
        settle();
        chk("contend_count", 32'(bus.wr_count), 32'd6);

        // Illegal select: dropped, sticky flag, pointer wraps to 0
        set_req(0, 1, 2'd0, 8'h44);
        settle();
        edge_();
        bus.req_valid = '0;
        set_req(2, 1, 2'd3, 8'h55);
        settle();
        chk("ill_ready", 32'(bus.req_ready), 32'd4);
        edge_();
        bus.req_valid = '0;
        settle();
        chk("ill_wr",   32'(bus.reg_write),   32'd0);
        chk("ill_flag", 32'(bus.illegal_sel), 32'd1);
        set_req(0, 1, 2'd0, 8'h66);
        set_req(1, 1, 2'd1, 8'h77);
        set_req(2, 1, 2'd2, 8'h88);
        settle();
        chk("ill_next_rr", 32'(bus.req_ready), 32'd1);
        edge_();
        bus.req_valid = '0;
        settle();
        edge_();

        // Hold: captured write still issues, new grants resume when hold drops
        set_req(0, 1, 2'd2, 8'h99);
        settle();
        edge_();
        bus.req_valid = '0;
        bus.wr_hold   = 1'b1;
        set_req(1, 1, 2'd1, 8'hAA);
        settle();
        chk("hold_issue", 32'(bus.reg_write), 32'd1);
        chk("hold_ready", 32'(bus.req_ready), 32'd0);
        edge_();
        settle();
        chk("hold_ready2", 32'(bus.req_ready), 32'd0);
        bus.wr_hold = 1'b0;
        settle();
        chk("hold_resume", 32'(bus.req_ready), 32'd2);
        edge_();
        bus.req_valid = '0;
        settle();
        edge_();

        // Saturation
        set_req(0, 1, 2'd1, 8'h5A);
        for (int c = 0; c < 260; c++) begin
            settle();
            edge_();
        end
        bus.req_valid = '0;
        settle();
        edge_();
        settle();
        chk("sat_count", 32'(bus.wr_count), 32'd255);
        edge_();
        settle();
        chk("sat_hold", 32'(bus.wr_count), 32'd255);

        // Randomized traffic; requesters hold until granted
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 2 == 0)) begin
                    pend[i] = 1;
                    set_req(i, 1, 2'($urandom % 4), 8'($urandom));
                end
                bus.req_valid[i] = pend[i];
            end
            bus.wr_hold = ($urandom % 5 == 0);
            bus.rd_sel  = 2'($urandom % 4);
            settle();
            edge_();
            if (last_grant >= 0) pend[last_grant] = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
